// File: rtl/mem_arbiter.sv
// mem_arbiter: N_CH-channel arbiter in front of a single-port RAM.
// IDLE samples requests and picks a winner (fixed priority or round-robin),
// ACCESS drives the RAM for 1+WAIT_STATES cycles, DONE pulses completion.
// All outputs come straight from registers.
module mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int N_CH        = 2,
    parameter int WAIT_STATES = 0,
    parameter int FIXED_PRIO  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          we,
    input  logic [N_CH*ADDR_W-1:0]   addr,
    input  logic [N_CH*DATA_W-1:0]   wdata,
    output logic [N_CH-1:0]          gnt,
    output logic [N_CH-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata
);

    localparam int IDX_W = $clog2(N_CH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                lat_we_q, lat_we_d;
    logic [N_CH-1:0]     gnt_q, gnt_d;
    logic [N_CH-1:0]     done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

    logic                found_s;
    logic [IDX_W-1:0]    pick_s;

    // Winner search: fixed order from channel 0, or rotating start after last winner.
    always_comb begin
        int  cand_v;
        logic hit_v;
        found_s = 1'b0;
        pick_s  = '0;
        cand_v  = 0;
        hit_v   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            cand_v  = (FIXED_PRIO != 0) ? k : (int'(last_q) + 1 + k);
            cand_v  = (cand_v >= N_CH) ? (cand_v - N_CH) : cand_v;
            hit_v   = !found_s && req[cand_v];
            pick_s  = hit_v ? IDX_W'(cand_v) : pick_s;
            found_s = found_s | hit_v;
        end
    end

    // Next-state and registered-output computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        lat_we_d    = lat_we_q;
        rdata_d     = rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        gnt_d       = '0;
        done_d      = '0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    state_d       = S_ACCESS;
                    win_d         = pick_s;
                    last_d        = pick_s;
                    cnt_d         = 3'(WAIT_STATES);
                    lat_we_d      = we[pick_s];
                    ram_addr_d    = addr[int'(pick_s)*ADDR_W +: ADDR_W];
                    ram_wdata_d   = wdata[int'(pick_s)*DATA_W +: DATA_W];
                    gnt_d[pick_s] = 1'b1;
                    ram_en_d      = 1'b1;
                    ram_we_d      = we[pick_s];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    // Last access cycle: capture read data, reads only.
                    state_d       = S_DONE;
                    done_d[win_q] = 1'b1;
                    rdata_d       = lat_we_q ? rdata_q : ram_rdata;
                end else begin
                    cnt_d    = cnt_q - 3'd1;
                    ram_en_d = 1'b1;
                    ram_we_d = lat_we_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            win_q       <= '0;
            last_q      <= IDX_W'(N_CH - 1);
            cnt_q       <= 3'd0;
            lat_we_q    <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            lat_we_q    <= lat_we_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: five instances with different
// channel counts, wait states and priority modes share one clock.
module tb_mem_arbiter;

    localparam int ND = 5;
    localparam int NC_T [ND] = '{2, 2, 4, 3, 2};
    localparam int WS_T [ND] = '{0, 2, 1, 0, 3};
    localparam int FP_T [ND] = '{0, 0, 1, 0, 0};

    typedef struct {
        int          ch;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    // Free-running cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  req_u   [ND];
    logic [3:0]  we_u    [ND];
    logic [15:0] addr_u  [ND][4];
    logic [31:0] wdata_u [ND][4];
    logic        rst_u   [ND];

    logic [3:0]  gnt_u       [ND];
    logic [3:0]  done_u      [ND];
    logic [31:0] rdata_u     [ND];
    logic [31:0] ram_wdata_u [ND];
    logic [15:0] ram_addr_u  [ND];
    logic        ram_en_u    [ND];
    logic        ram_we_u    [ND];

    txn_t exp_q [ND][$];

    int   checks = 0;
    int   failures = 0;
    int   tmo_cnt = 0;
    int   tmo_seen = 0;
    logic end_req = 1'b0;
    logic end_ack = 1'b0;

    function automatic logic [31:0] ram_model(input logic [15:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        return {a, ~a};
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        if (!$onehot(v)) return -1;
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    for (genvar d = 0; d < ND; d++) begin : g_dut
        localparam int NC = NC_T[d];
        logic [NC-1:0]    req_w, we_w, gnt_w, done_w;
        logic [NC*16-1:0] addr_w;
        logic [NC*32-1:0] wdata_w;
        logic [15:0]      ram_addr_w;
        logic [31:0]      ram_rdata_w, ram_wdata_w, rdata_w;
        logic             ram_en_w, ram_we_w;

        assign req_w = req_u[d][NC-1:0];
        assign we_w  = we_u[d][NC-1:0];
        for (genvar c = 0; c < NC; c++) begin : g_ch
            assign addr_w[c*16 +: 16]  = addr_u[d][c];
            assign wdata_w[c*32 +: 32] = wdata_u[d][c];
        end
        assign ram_rdata_w    = ram_model(ram_addr_w);
        assign gnt_u[d]       = 4'(gnt_w);
        assign done_u[d]      = 4'(done_w);
        assign rdata_u[d]     = rdata_w;
        assign ram_wdata_u[d] = ram_wdata_w;
        assign ram_addr_u[d]  = ram_addr_w;
        assign ram_en_u[d]    = ram_en_w;
        assign ram_we_u[d]    = ram_we_w;

        mem_arbiter #(
            .DATA_W(32), .ADDR_W(16), .N_CH(NC),
            .WAIT_STATES(WS_T[d]), .FIXED_PRIO(FP_T[d])
        ) u_dut (
            .clk(clk), .reset(rst_u[d]), .req(req_w), .we(we_w),
            .addr(addr_w), .wdata(wdata_w), .gnt(gnt_w), .done(done_w),
            .rdata(rdata_w), .ram_en(ram_en_w), .ram_we(ram_we_w),
            .ram_addr(ram_addr_w), .ram_wdata(ram_wdata_w),
            .ram_rdata(ram_rdata_w)
        );
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, d, $time, act, exp_v);
        end
    endtask

    // Monitor state, one slot per instance.
    logic busy     [ND] = '{default: 1'b0};
    logic prev_rst [ND] = '{default: 1'b0};
    int   gcyc     [ND] = '{default: 0};
    int   gch      [ND] = '{default: 0};
    int   en_cnt   [ND] = '{default: 0};

    // Monitor: watches every instance on the falling edge and scores against the queues.
    always @(negedge clk) begin
        txn_t t;
        for (int d = 0; d < ND; d++) begin
            if (!prev_rst[d]) begin
                chk("reset_ctl", d, {20'd0, gnt_u[d], done_u[d], 2'b00, ram_en_u[d], ram_we_u[d]}, 32'd0);
                chk("reset_rdata", d, rdata_u[d], 32'd0);
                chk("reset_ram_addr", d, {16'd0, ram_addr_u[d]}, 32'd0);
                if (busy[d] && exp_q[d].size() > 0) t = exp_q[d].pop_front();
                busy[d] = 1'b0;
            end else begin
                if (gnt_u[d] != 4'd0) begin
                    chk("gnt_while_busy", d, {31'd0, busy[d]}, 32'd0);
                    busy[d]   = 1'b1;
                    gch[d]    = onehot_idx(gnt_u[d]);
                    gcyc[d]   = cyc;
                    en_cnt[d] = 0;
                end
                if (ram_en_u[d]) begin
                    if (!busy[d] || exp_q[d].size() == 0) begin
                        chk("ram_en_unexpected", d, 32'd1, 32'd0);
                    end else begin
                        t = exp_q[d][0];
                        en_cnt[d]++;
                        chk("ram_addr", d, {16'd0, ram_addr_u[d]}, {16'd0, t.addr});
                        chk("ram_we", d, {31'd0, ram_we_u[d]}, {31'd0, t.we});
                        chk("ram_wdata", d, ram_wdata_u[d], t.wdata);
                    end
                end
                if (done_u[d] != 4'd0) begin
                    if (!busy[d] || exp_q[d].size() == 0) begin
                        chk("done_unexpected", d, {28'd0, done_u[d]}, 32'd0);
                    end else begin
                        t = exp_q[d].pop_front();
                        chk("gnt_channel", d, gch[d], t.ch);
                        chk("done_channel", d, {28'd0, done_u[d]}, 32'd1 << t.ch);
                        chk("gnt_to_done", d, cyc - gcyc[d], 1 + WS_T[d]);
                        chk("ram_en_cycles", d, en_cnt[d], 1 + WS_T[d]);
                        chk("ram_idle_in_done", d, {30'd0, ram_en_u[d], ram_we_u[d]}, 32'd0);
                        chk("rdata", d, rdata_u[d], t.rdata);
                        busy[d] = 1'b0;
                    end
                end
            end
            prev_rst[d] = rst_u[d];
        end
        if (tmo_cnt != tmo_seen) begin
            chk("wait_timeout", 0, tmo_cnt, tmo_seen);
            tmo_seen = tmo_cnt;
        end
        if (end_req && !end_ack) begin
            for (int d = 0; d < ND; d++) chk("missing_done", d, exp_q[d].size(), 32'd0);
            end_ack = 1'b1;
        end
    end

    task automatic push(input int d, input int ch, input logic w, input logic [15:0] a,
                        input logic [31:0] wd, input logic [31:0] rd);
        txn_t t;
        t.ch = ch; t.we = w; t.addr = a; t.wdata = wd; t.rdata = rd;
        exp_q[d].push_back(t);
    endtask

    // Hold req until n grants are seen, then optionally pulse a late req for one cycle.
    task automatic run(input int d, input logic [3:0] m, input int n, input logic [3:0] pulse);
        int g = 0;
        int budget = 0;
        req_u[d] = m;
        while (g < n && budget < 200) begin
            @(posedge clk); #1;
            budget++;
            if (gnt_u[d] != 4'd0) g++;
        end
        req_u[d] = 4'd0;
        if (g < n) tmo_cnt++;
        if (pulse != 4'd0) begin
            req_u[d] = pulse;
            @(posedge clk); #1;
            req_u[d] = 4'd0;
        end
        repeat (WS_T[d] + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        for (int d = 0; d < ND; d++) begin
            req_u[d] = 4'd0; we_u[d] = 4'd0; rst_u[d] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                addr_u[d][c] = 16'd0; wdata_u[d][c] = 32'd0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) rst_u[d] = 1'b1;

        // Instance 0: single read of DEADBEEF, round-robin 0,1,0,1, dropped req ignored.
        addr_u[0][0] = 16'h0100; addr_u[0][1] = 16'h0010;
        push(0, 1, 1'b0, 16'h0010, 32'd0, 32'hDEADBEEF);
        run(0, 4'b0010, 1, 4'd0);
        push(0, 0, 1'b0, 16'h0100, 32'd0, 32'h0100FEFF);
        push(0, 1, 1'b0, 16'h0010, 32'd0, 32'hDEADBEEF);
        push(0, 0, 1'b0, 16'h0100, 32'd0, 32'h0100FEFF);
        push(0, 1, 1'b0, 16'h0010, 32'd0, 32'hDEADBEEF);
        run(0, 4'b0011, 4, 4'd0);
        push(0, 0, 1'b0, 16'h0100, 32'd0, 32'h0100FEFF);
        run(0, 4'b0001, 1, 4'b0010);

        // Instance 1: read then write with two wait states; write keeps rdata.
        addr_u[1][1] = 16'h0020;
        push(1, 1, 1'b0, 16'h0020, 32'd0, 32'h0020FFDF);
        run(1, 4'b0010, 1, 4'd0);
        we_u[1] = 4'b0001; addr_u[1][0] = 16'h0004; wdata_u[1][0] = 32'h12345678;
        push(1, 0, 1'b1, 16'h0004, 32'h12345678, 32'h0020FFDF);
        run(1, 4'b0001, 1, 4'd0);

        // Instance 2: fixed priority, four channels.
        for (int c = 0; c < 4; c++) addr_u[2][c] = 16'h0030 + 16'(c);
        for (int k = 0; k < 3; k++) push(2, 1, 1'b0, 16'h0031, 32'd0, 32'h0031FFCE);
        run(2, 4'b1110, 3, 4'd0);
        push(2, 3, 1'b0, 16'h0033, 32'd0, 32'h0033FFCC);
        run(2, 4'b1000, 1, 4'd0);
        push(2, 0, 1'b0, 16'h0030, 32'd0, 32'h0030FFCF);
        run(2, 4'b1111, 1, 4'd0);

        // Instance 3: three-channel round-robin wrap-around.
        for (int c = 0; c < 3; c++) addr_u[3][c] = 16'h0040 + 16'(c);
        push(3, 2, 1'b0, 16'h0042, 32'd0, 32'h0042FFBD);
        run(3, 4'b0100, 1, 4'd0);
        push(3, 0, 1'b0, 16'h0040, 32'd0, 32'h0040FFBF);
        push(3, 2, 1'b0, 16'h0042, 32'd0, 32'h0042FFBD);
        run(3, 4'b0101, 2, 4'd0);

        // Instance 4: reset during the second access cycle, then restart from channel 0.
        addr_u[4][0] = 16'h0051; addr_u[4][1] = 16'h0050;
        push(4, 1, 1'b0, 16'h0050, 32'd0, 32'h0050FFAF);
        req_u[4] = 4'b0010;
        budget = 0;
        while (gnt_u[4] == 4'd0 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (gnt_u[4] == 4'd0) tmo_cnt++;
        req_u[4] = 4'd0;
        @(posedge clk); #1;
        rst_u[4] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_u[4] = 1'b1;
        push(4, 0, 1'b0, 16'h0051, 32'd0, 32'h0051FFAE);
        push(4, 1, 1'b0, 16'h0050, 32'd0, 32'h0050FFAF);
        run(4, 4'b0011, 2, 4'd0);

        repeat (4) @(posedge clk);
        end_req = 1'b1;
        budget = 0;
        while (!end_ack && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (!end_ack) begin
            $display("FAIL end_handshake actual=0 expected=1");
            $fatal(1, "monitor did not acknowledge end of test");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
